pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter unit that forms the instruction-fetch address and sits directly downstream of the branch unit: it consumes the branch-taken decision plus jump signals from execute, computes the redirect target and updates the PC. It also handles the fetch request/ready handshake to instruction memory and raises a one-cycle pipeline flush on every redirect. A misaligned redirect target traps the unit, which stops fetching until reset.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the redirect counter.

Ports:
- PCU_CLOCK_50  in  1  single clock; all state updates on its rising edge.
- PCU_RESET_InHigh  in  1  reset; asynchronous and active-high.
- PCU_branch_taken  in  1  conditional branch taken (branch-unit enable output).
- PCU_jal  in  1  JAL in execute.
- PCU_jalr  in  1  JALR in execute.
- PCU_ex_pc_InBUS  in  32  PC of the instruction in execute.
- PCU_imm_InBUS  in  32  sign-extended immediate of that instruction.
- PCU_rs1_data_InBUS  in  32  rs1 operand (used for JALR only).
- PCU_stall  in  1  hazard stall from decode; holds the fetch PC.
- PCU_imem_ready  in  1  instruction memory accepts the request this cycle.
- PCU_imem_req  out  1  fetch request valid.
- PCU_pc_OutBUS  out  32  fetch address (registered).
- PCU_flush  out  1  kill IF/ID contents at the next edge.
- PCU_misaligned  out  1  sticky trap flag.
- PCU_redirect_cnt_OutBUS  out  COUNT_WIDTH  number of redirects taken.

## Operation
States:
- IDLE: entered on reset.
- FETCH: normal fetching.
- TRAP: fetching stopped after a misaligned redirect.

Transitions:
- IDLE -> FETCH at the first rising edge after reset is released.
- FETCH -> TRAP on a redirect whose target[1:0] != 2'b00.
- TRAP is exited only by reset.

Redirect:
- redirect = (PCU_jalr | PCU_jal | PCU_branch_taken) while in FETCH.
- Redirect inputs are ignored in IDLE and in TRAP.
- Target source priority: jalr > jal > branch.
- JALR target = (rs1 + imm) & 32'hFFFF_FFFE.
- JAL and branch target = ex_pc + imm.
- All additions are 32-bit modulo 2^32; carry-out is discarded.

PC update in FETCH, highest priority first:
1. Aligned redirect: PC <= target; counter <= counter + 1 (wraps at 2^COUNT_WIDTH); stall and ready are ignored.
2. Misaligned redirect: PC is held; state <= TRAP; PCU_misaligned <= 1; the counter is not incremented.
3. PCU_imem_req & PCU_imem_ready: PC <= PC + 4 (wraps from 32'hFFFF_FFFC to 0).
4. Otherwise: PC is held.

Outputs:
- PCU_imem_req = (state == FETCH) & ~PCU_stall. This is combinational; a request is never raised during a stall.
- PCU_flush = redirect & (aligned target). This is combinational and asserted in the same cycle the redirect inputs are present.
- A misaligned redirect does not flush; PCU_misaligned is the only indication.

## Timing
Reset values:
- PCU_pc_OutBUS = RESET_VECTOR
- state = IDLE
- PCU_imem_req = 0
- PCU_flush = 0
- PCU_misaligned = 0
- PCU_redirect_cnt_OutBUS = 0

Latency and handshake:
- Redirect latency: target appears on PCU_pc_OutBUS one cycle after the redirect inputs; flush is high during the input cycle.
- Handshake: the address is transferred only on a cycle where req and ready are both high. While req is high and ready is low, PC is held and req stays high, unless a stall or redirect intervenes.

Boundary conditions:
- Simultaneous redirect and accepted fetch: the redirect wins; the accepted fetch is wrong-path and is killed by the flush.
- Simultaneous redirect and stall: the redirect wins.
- Back-to-back redirects in consecutive cycles: each is taken; the counter increments twice.
- Reset asserted mid-operation, including in TRAP: all state returns to its reset values immediately, without waiting for a clock edge.
- Counter at its maximum value (all ones) plus one redirect wraps to 0.

## Test plan
- Reset with RESET_VECTOR=0x100, ready=1, no stall -> PC 0x100 for IDLE cycle, then 0x100, 0x104, 0x108 on successive cycles with req=1.
- ready=0 for 3 cycles at PC 0x104 -> PC stays 0x104, req stays 1; advances to 0x108 one cycle after ready=1.
- Branch: ex_pc=0x200, imm=0xFFFFFFF0, branch_taken=1 -> flush=1 that cycle, next PC 0x1F0, counter=1.
- JALR with jal and branch also high: rs1=0x1003, imm=4 -> target 0x1006 misaligned -> TRAP, misaligned=1, req=0, no flush, counter unchanged; then reset clears all.
- Stall=1 with ready=1 -> req=0, PC held; same cycle jal with ex_pc=0x40, imm=0x20 -> PC 0x60 next cycle.
- Counter preset near the wrap point (COUNT_WIDTH=2): 4 consecutive redirects -> count reads 1, 2, 3, 0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: forms the fetch address, applies branch/jump redirects
// from execute, runs the imem request/ready handshake and traps on misaligned targets.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   PCU_CLOCK_50,
  input  logic                   PCU_RESET_InHigh,
  input  logic                   PCU_branch_taken,
  input  logic                   PCU_jal,
  input  logic                   PCU_jalr,
  input  logic [31:0]            PCU_ex_pc_InBUS,
  input  logic [31:0]            PCU_imm_InBUS,
  input  logic [31:0]            PCU_rs1_data_InBUS,
  input  logic                   PCU_stall,
  input  logic                   PCU_imem_ready,
  output logic                   PCU_imem_req,
  output logic [31:0]            PCU_pc_OutBUS,
  output logic                   PCU_flush,
  output logic                   PCU_misaligned,
  output logic [COUNT_WIDTH-1:0] PCU_redirect_cnt_OutBUS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] jalr_target;
  logic [31:0] rel_target;
  logic [31:0] target;
  logic        redirect;
  logic        target_aligned;
  logic        take_redirect;
  logic        bad_redirect;
  logic        fetch_accept;

  // JALR clears bit 0 of its sum; JAL and branches share the pc-relative adder.
  always_comb begin
    jalr_target    = (PCU_rs1_data_InBUS + PCU_imm_InBUS) & 32'hFFFF_FFFE;
    rel_target     = PCU_ex_pc_InBUS + PCU_imm_InBUS;
    target         = PCU_jalr ? jalr_target : rel_target;
    target_aligned = (target[1:0] == 2'b00);
    redirect       = (state == FETCH) & (PCU_jalr | PCU_jal | PCU_branch_taken);
    take_redirect  = redirect & target_aligned;
    bad_redirect   = redirect & ~target_aligned;
    fetch_accept   = PCU_imem_req & PCU_imem_ready;
  end

  always_ff @(posedge PCU_CLOCK_50 or posedge PCU_RESET_InHigh) begin
    if (PCU_RESET_InHigh) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (bad_redirect) state_next = TRAP;
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    PCU_imem_req = (state == FETCH) & ~PCU_stall;
    PCU_flush    = take_redirect;
  end

  // A redirect overrides stall and any accepted fetch; a misaligned one freezes the PC.
  always_ff @(posedge PCU_CLOCK_50 or posedge PCU_RESET_InHigh) begin
    if (PCU_RESET_InHigh) begin
      PCU_pc_OutBUS           <= RESET_VECTOR;
      PCU_misaligned          <= 1'b0;
      PCU_redirect_cnt_OutBUS <= '0;
    end else if (take_redirect) begin
      PCU_pc_OutBUS           <= target;
      PCU_redirect_cnt_OutBUS <= PCU_redirect_cnt_OutBUS + COUNT_WIDTH'(1);
    end else if (bad_redirect) begin
      PCU_misaligned <= 1'b1;
    end else if (fetch_accept) begin
      PCU_pc_OutBUS <= PCU_pc_OutBUS + 32'd4;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed per-cycle vectors push hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        stall = 1'b0;
  logic        ready = 1'b1;
  logic        imem_req;
  logic [31:0] pc;
  logic        flush;
  logic        misaligned;
  logic [1:0]  cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        flush;
    logic        mis;
    logic [1:0]  cnt;
    string       name;
  } exp_t;

  exp_t sb[$];

  pc_unit #(.RESET_VECTOR(32'h0000_0100), .COUNT_WIDTH(2)) dut (
    .PCU_CLOCK_50            (clk),
    .PCU_RESET_InHigh        (rst),
    .PCU_branch_taken        (branch_taken),
    .PCU_jal                 (jal),
    .PCU_jalr                (jalr),
    .PCU_ex_pc_InBUS         (ex_pc),
    .PCU_imm_InBUS           (imm),
    .PCU_rs1_data_InBUS      (rs1),
    .PCU_stall               (stall),
    .PCU_imem_ready          (ready),
    .PCU_imem_req            (imem_req),
    .PCU_pc_OutBUS           (pc),
    .PCU_flush               (flush),
    .PCU_misaligned          (misaligned),
    .PCU_redirect_cnt_OutBUS (cnt)
  );

  always #5 clk = ~clk;

  // One call drives one cycle's inputs just after the rising edge and queues
  // what the outputs must show in the middle of that cycle.
  task automatic applyStimulus(
    input string       name,
    input logic        r, br, j, jr, st, rdy,
    input logic [31:0] epc, im, rs,
    input logic [31:0] e_pc,
    input logic        e_req, e_flush, e_mis,
    input logic [1:0]  e_cnt
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; branch_taken = br; jal = j; jalr = jr; stall = st; ready = rdy;
    ex_pc = epc; imm = im; rs1 = rs;
    e.pc = e_pc; e.req = e_req; e.flush = e_flush; e.mis = e_mis; e.cnt = e_cnt;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 5;
    if (pc !== e.pc) begin
      errors++;
      $display("[TB] FAIL %s pc: got %h want %h", e.name, pc, e.pc);
    end
    if (imem_req !== e.req) begin
      errors++;
      $display("[TB] FAIL %s req: got %b want %b", e.name, imem_req, e.req);
    end
    if (flush !== e.flush) begin
      errors++;
      $display("[TB] FAIL %s flush: got %b want %b", e.name, flush, e.flush);
    end
    if (misaligned !== e.mis) begin
      errors++;
      $display("[TB] FAIL %s misaligned: got %b want %b", e.name, misaligned, e.mis);
    end
    if (cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s cnt: got %0d want %0d", e.name, cnt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    //             name          rst br jal jr st rdy ex_pc         imm           rs1           pc            req flush mis cnt
    applyStimulus("reset",       1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 0, 0, 2'd0);
    applyStimulus("idle",        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 0, 0, 2'd0);
    applyStimulus("fetch0",      0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 1, 0, 0, 2'd0);
    applyStimulus("wait1",       0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0104, 1, 0, 0, 2'd0);
    applyStimulus("wait2",       0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0104, 1, 0, 0, 2'd0);
    applyStimulus("wait3",       0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0104, 1, 0, 0, 2'd0);
    applyStimulus("ready_back",  0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0104, 1, 0, 0, 2'd0);
    applyStimulus("fetch_108",   0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0108, 1, 0, 0, 2'd0);
    applyStimulus("branch",      0, 1, 0, 0, 0, 1, 32'h200,      32'hFFFF_FFF0, 32'h0,       32'h0000_010C, 1, 1, 0, 2'd0);
    applyStimulus("stall_jal",   0, 0, 1, 0, 1, 1, 32'h40,       32'h20,       32'h0,        32'h0000_01F0, 0, 1, 0, 2'd1);
    applyStimulus("stall_hold",  0, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0060, 0, 0, 0, 2'd2);
    applyStimulus("b2b_jal",     0, 0, 1, 0, 0, 1, 32'h300,      32'h10,       32'h0,        32'h0000_0060, 1, 1, 0, 2'd2);
    applyStimulus("b2b_branch",  0, 1, 0, 0, 0, 1, 32'h400,      32'h8,        32'h0,        32'h0000_0310, 1, 1, 0, 2'd3);
    applyStimulus("jalr_mask",   0, 0, 0, 1, 0, 1, 32'h0,        32'h4,        32'h501,      32'h0000_0408, 1, 1, 0, 2'd0);
    applyStimulus("after_jalr",  0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0504, 1, 0, 0, 2'd1);
    applyStimulus("misalign",    0, 1, 1, 1, 0, 1, 32'h600,      32'h4,        32'h1003,     32'h0000_0508, 1, 0, 0, 2'd1);
    applyStimulus("trap_ignore", 0, 0, 1, 0, 0, 1, 32'h600,      32'h4,        32'h0,        32'h0000_0508, 0, 0, 1, 2'd1);
    applyStimulus("trap_stays",  0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0508, 0, 0, 1, 2'd1);
    applyStimulus("async_rst",   1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 0, 0, 0, 2'd0);
    applyStimulus("idle_ignore", 0, 0, 1, 0, 0, 1, 32'h600,      32'h4,        32'h0,        32'h0000_0100, 0, 0, 0, 2'd0);
    applyStimulus("refetch0",    0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0100, 1, 0, 0, 2'd0);
    applyStimulus("refetch1",    0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0000_0104, 1, 0, 0, 2'd0);
    applyStimulus("jal_top",     0, 0, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'hC,       32'h0,        32'h0000_0108, 1, 1, 0, 2'd0);
    applyStimulus("pc_wrap",     0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, 1, 0, 0, 2'd1);
    applyStimulus("jal_carry",   0, 0, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'h14,      32'h0,        32'h0000_0000, 1, 1, 0, 2'd1);
    applyStimulus("final",       0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 1, 0, 0, 2'd2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
